return_tracker: RTL and testbench

- Issue-side counterpart to the TX returner. It hands out request tags for outstanding reads and writes.
- It consumes the returner's completion stream: wd/rd strobes, with the tag carried on data.
- It retires completed tags strictly in allocation order to the TX controller over a valid/ready handshake.
- It sits between the TX request scheduler (allocation), the returner (completion) and TX retirement logic.

---
 rtl/tx_ret_pkg.sv | 39 +++
 rtl/tag_ring_ptr.sv | 24 ++
 rtl/return_tracker.sv | 166 ++++++++++++++++
 tb/tb_return_tracker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_ret_pkg.sv
// tx_ret_pkg: shared definitions for the return tracker.
//   - NUM_TAGS_DEF / TAG_W_DEF : default tag-table size and derived tag width
//   - entry_t                  : per-slot state {busy, done, is_read, timed_out}
//   - STB_*                    : encoding of the {wd, rd} return strobe pair
//   - strobe_legal()           : decides whether a return may complete a slot
package tx_ret_pkg;

    localparam int NUM_TAGS_DEF = 16;
    localparam int TAG_W_DEF    = $clog2(NUM_TAGS_DEF);

    typedef struct packed {
        logic busy;
        logic done;
        logic is_read;
        logic timed_out;
    } entry_t;

    // {wd, rd}
    localparam logic [1:0] STB_NONE = 2'b00;
    localparam logic [1:0] STB_RD   = 2'b01;
    localparam logic [1:0] STB_WR   = 2'b10;
    localparam logic [1:0] STB_BOTH = 2'b11;

    // A return completes a slot only if the slot is waiting and the strobe
    // type matches the transaction type recorded at allocation.
    function automatic logic strobe_legal(input logic [1:0] stb,
                                          input logic       busy,
                                          input logic       done,
                                          input logic       is_read);
        logic ok;
        case (stb)
            STB_WR:  ok = busy && !done && !is_read;
            STB_RD:  ok = busy && !done && is_read;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tag_ring_ptr.sv
// tag_ring_ptr: wrapping TAG_W-bit pointer with increment enable.
//   clk  : clock
//   rst  : asynchronous active-low reset (pointer clears to 0)
//   inc  : advance the pointer by one this cycle
//   ptr  : current pointer value (wraps modulo 2**TAG_W)
module tag_ring_ptr #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [TAG_W-1:0] ptr
);

    // Pointer register; natural binary wrap gives modulo NUM_TAGS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + TAG_W'(1);
        end
    end

endmodule

// File: rtl/return_tracker.sv
// return_tracker: hands out tags for outstanding reads/writes, marks them
// complete from the returner's wd/rd strobes (tag on data[TAG_W-1:0]) and
// retires completed tags strictly in allocation order.
//
// Ports:
//   clk, rst (async, active-low)
//   alloc_req, alloc_is_read -> alloc_gnt, alloc_tag   (zero-latency grant)
//   wd, rd, data                                       (completion stream)
//   retire_valid, retire_ready, retire_tag, retire_is_read, retire_timeout
//   outstanding (busy entry count), err_unexpected (one-cycle pulse)
//
// Build option: define RETURN_TIMEOUT_EN to force-complete the oldest entry
// after TIMEOUT_CYCLES without a return; otherwise retire_timeout is 0.
module return_tracker
    import tx_ret_pkg::*;
#(
    parameter int  NUM_TAGS       = NUM_TAGS_DEF,
    parameter int  DATA_W         = 32,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int TAG_W          = $clog2(NUM_TAGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic              alloc_is_read,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wd,
    input  logic              rd,
    input  logic [DATA_W-1:0] data,
    output logic              retire_valid,
    input  logic              retire_ready,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              retire_is_read,
    output logic              retire_timeout,
    output logic [TAG_W:0]    outstanding,
    output logic              err_unexpected
);

    entry_t           table_r [NUM_TAGS];
    logic [TAG_W:0]   count_r;
    logic [TAG_W:0]   count_next_s;
    logic [TAG_W-1:0] head_s;
    logic [TAG_W-1:0] tail_s;
    logic [TAG_W-1:0] ret_tag_s;
    logic [1:0]       strobe_s;
    logic             full_s;
    logic             ret_any_s;
    logic             ret_legal_s;
    logic             retire_fire_s;
    logic             timeout_hit_s;
    logic             unused_data_s;

    assign ret_tag_s     = data[TAG_W-1:0];
    assign unused_data_s = ^data[DATA_W-1:TAG_W];
    assign strobe_s      = {wd, rd};
    assign ret_any_s     = wd | rd;
    assign ret_legal_s   = strobe_legal(strobe_s, table_r[ret_tag_s].busy,
                                        table_r[ret_tag_s].done,
                                        table_r[ret_tag_s].is_read);

    assign full_s         = (count_r == (TAG_W+1)'(NUM_TAGS));
    // Gated by rst so the grant reads 0 while reset is held.
    assign alloc_gnt      = alloc_req && !full_s && rst;
    assign alloc_tag      = head_s;
    assign retire_valid   = table_r[tail_s].busy && table_r[tail_s].done;
    assign retire_tag     = tail_s;
    assign retire_is_read = table_r[tail_s].is_read;
    assign retire_fire_s  = retire_valid && retire_ready;
    assign outstanding    = count_r;

    tag_ring_ptr #(.TAG_W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (alloc_gnt),
        .ptr (head_s)
    );

    tag_ring_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (retire_fire_s),
        .ptr (tail_s)
    );

`ifdef RETURN_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [AGE_W-1:0] age_r;
    logic             tail_waiting_s;
    logic             ret_to_tail_s;

    assign tail_waiting_s = table_r[tail_s].busy && !table_r[tail_s].done;
    assign ret_to_tail_s  = ret_any_s && (ret_tag_s == tail_s);
    // A return to the tail in the same cycle restarts the age instead of timing out.
    assign timeout_hit_s  = tail_waiting_s && !ret_to_tail_s &&
                            (age_r == AGE_W'(TIMEOUT_CYCLES - 1));
    assign retire_timeout = retire_valid && table_r[tail_s].timed_out;

    // Age of the oldest waiting entry; restarts on any tail change or tail return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_r <= '0;
        end else if (!tail_waiting_s || ret_to_tail_s || timeout_hit_s) begin
            age_r <= '0;
        end else begin
            age_r <= age_r + AGE_W'(1);
        end
    end
`else
    localparam int unused_timeout_p = TIMEOUT_CYCLES;

    assign timeout_hit_s  = 1'b0;
    assign retire_timeout = 1'b0;
`endif

    // Net change of the busy count: simultaneous alloc and retire cancel.
    always_comb begin
        count_next_s = count_r;
        case ({alloc_gnt, retire_fire_s})
            2'b10:   count_next_s = count_r + (TAG_W+1)'(1);
            2'b01:   count_next_s = count_r - (TAG_W+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Tag table. Retire, timeout, legal return and allocate never hit the same
    // slot in one cycle: retire needs done=1, timeout/return need done=0, and
    // allocation targets an idle slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                table_r[i] <= '0;
            end
        end else begin
            if (retire_fire_s) begin
                table_r[tail_s].busy      <= 1'b0;
                table_r[tail_s].done      <= 1'b0;
                table_r[tail_s].timed_out <= 1'b0;
            end
            if (timeout_hit_s) begin
                table_r[tail_s].done      <= 1'b1;
                table_r[tail_s].timed_out <= 1'b1;
            end
            if (ret_legal_s) begin
                table_r[ret_tag_s].done <= 1'b1;
            end
            if (alloc_gnt) begin
                table_r[head_s] <= '{busy: 1'b1, done: 1'b0,
                                     is_read: alloc_is_read, timed_out: 1'b0};
            end
        end
    end

    // Busy count and the illegal-return pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r        <= '0;
            err_unexpected <= 1'b0;
        end else begin
            count_r        <= count_next_s;
            err_unexpected <= ret_any_s && !ret_legal_s;
        end
    end

endmodule

// File: tb/tb_return_tracker.sv
// tb_return_tracker: directed + randomized bench for return_tracker with a
// queue-based reference model and a decoupled retirement scoreboard.
// Define RETURN_TIMEOUT_EN to also exercise the timeout feature (TO=8).
module tb_return_tracker;

    localparam int NUM = 16;
    localparam int TW  = 4;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req, alloc_is_read, alloc_gnt;
    logic [TW-1:0] alloc_tag;
    logic          wd, rd;
    logic [DW-1:0] data;
    logic          retire_valid, retire_ready, retire_is_read, retire_timeout;
    logic [TW-1:0] retire_tag;
    logic [TW:0]   outstanding;
    logic          err_unexpected;

    int n_checks = 0;
    int n_errors = 0;

    return_tracker #(.NUM_TAGS(NUM), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_is_read  (alloc_is_read),
        .alloc_gnt      (alloc_gnt),
        .alloc_tag      (alloc_tag),
        .wd             (wd),
        .rd             (rd),
        .data           (data),
        .retire_valid   (retire_valid),
        .retire_ready   (retire_ready),
        .retire_tag     (retire_tag),
        .retire_is_read (retire_is_read),
        .retire_timeout (retire_timeout),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding transactions in allocation order.
    typedef struct {
        logic [TW-1:0] tag;
        logic          rd;
        logic          done;
        logic          tmo;
    } ment_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic          rd;
    } exp_t;

    ment_t m_q[$];
    exp_t  exp_q[$];
    int    m_next;
    int    m_age;
    logic  m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [TW-1:0] t);
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic do_reset(input logic hold_alloc);
        alloc_req = hold_alloc;
        rst = 1'b0;
        #1;
        chk("rst_alloc_gnt", 32'(alloc_gnt), 32'(0));
        chk("rst_retire_valid", 32'(retire_valid), 32'(0));
        chk("rst_retire_tag", 32'(retire_tag), 32'(0));
        chk("rst_retire_is_read", 32'(retire_is_read), 32'(0));
        chk("rst_retire_timeout", 32'(retire_timeout), 32'(0));
        chk("rst_outstanding", 32'(outstanding), 32'(0));
        chk("rst_err", 32'(err_unexpected), 32'(0));
        m_q.delete();
        exp_q.delete();
        m_next = 0;
        m_age  = 0;
        m_err  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        alloc_req = 1'b0;
        rst = 1'b1;
    endtask

    // One clock cycle: drive at posedge+2, check combinational outputs at the
    // negedge, advance the model at the posedge, check registered outputs +1.
    task automatic step(input logic areq, input logic aread, input logic w,
                        input logic r, input logic [TW-1:0] t, input logic rr);
        logic          exp_gnt, exp_rv, legal;
        int            idx;
        logic [DW-1:0] d;
        alloc_req = areq; alloc_is_read = aread; wd = w; rd = r; retire_ready = rr;
        d = DW'($urandom);
        d[TW-1:0] = t;
        data = d;
        @(negedge clk);
        exp_gnt = areq && (m_q.size() < NUM);
        exp_rv  = (m_q.size() > 0) ? m_q[0].done : 1'b0;
        chk("alloc_gnt", 32'(alloc_gnt), 32'(exp_gnt));
        if (exp_gnt) chk("alloc_tag", 32'(alloc_tag), 32'(m_next));
        chk("retire_valid", 32'(retire_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("retire_tag", 32'(retire_tag), 32'(m_q[0].tag));
            chk("retire_is_read", 32'(retire_is_read), 32'(m_q[0].rd));
            chk("retire_timeout", 32'(retire_timeout), 32'(m_q[0].tmo));
        end else begin
            chk("retire_timeout_idle", 32'(retire_timeout), 32'(0));
        end
        @(posedge clk);
        idx   = m_find(t);
        legal = 1'b0;
        if ((w ^ r) && idx >= 0) legal = !m_q[idx].done && (m_q[idx].rd == r);
        m_err = (w | r) && !legal;
`ifdef RETURN_TIMEOUT_EN
        if (m_q.size() == 0 || m_q[0].done) m_age = 0;
        else if ((w | r) && t == m_q[0].tag) m_age = 0;
        else if (m_age == TO - 1) begin
            m_q[0].done = 1'b1;
            m_q[0].tmo  = 1'b1;
            m_age = 0;
        end else m_age++;
`endif
        if (legal) m_q[idx].done = 1'b1;
        if (exp_rv && rr) void'(m_q.pop_front());
        if (exp_gnt) begin
            m_q.push_back('{tag: TW'(m_next), rd: aread, done: 1'b0, tmo: 1'b0});
            exp_q.push_back('{tag: TW'(m_next), rd: aread});
            m_next = (m_next + 1) % NUM;
        end
        #1;
        chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
        chk("outstanding", 32'(outstanding), 32'(m_q.size()));
        #1;
    endtask

    task automatic ret(input logic [TW-1:0] t, input logic rr);
        int   idx;
        logic isr;
        idx = m_find(t);
        isr = (idx >= 0) ? m_q[idx].rd : 1'b0;
        step(1'b0, 1'b0, !isr, isr, t, rr);
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, TW'(0), rr);
    endtask

    // Scoreboard monitor: every accepted retirement must be the oldest allocation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && retire_valid && retire_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL retire_order: retirement of tag %0d with none expected", retire_tag);
            end else begin
                e = exp_q.pop_front();
                chk("sb_retire_tag", 32'(retire_tag), 32'(e.tag));
                chk("sb_retire_is_read", 32'(retire_is_read), 32'(e.rd));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          isr;
        int            idx;
        int            kind;
        logic [TW-1:0] t;
        rst = 1'b0; alloc_req = 1'b0; alloc_is_read = 1'b0; wd = 1'b0; rd = 1'b0;
        data = '0; retire_ready = 1'b0;

        // Fill all 16 slots, then one request too many, then drain.
        do_reset(1'b1);
        for (int i = 0; i < NUM; i++) step(1'b1, (i % 2) == 0, 1'b0, 1'b0, TW'(0), 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, TW'(0), 1'b0);
        for (int i = 0; i < NUM; i++) ret(TW'(i), 1'b1);
        idle(3, 1'b1);

        // Reverse-order returns retire in allocation order.
        step(1'b1, 1'b1, 1'b0, 1'b0, TW'(0), 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, TW'(0), 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, TW'(0), 1'b1);
        ret(TW'(2), 1'b1);
        ret(TW'(1), 1'b1);
        ret(TW'(0), 1'b1);
        idle(4, 1'b1);

        // Illegal returns.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, TW'(0), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, TW'(3), 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, TW'(9), 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, TW'(4), 1'b1);
        ret(TW'(5), 1'b1);
        ret(TW'(5), 1'b1);
        ret(TW'(3), 1'b1);
        ret(TW'(0), 1'b1);
        ret(TW'(1), 1'b1);
        ret(TW'(2), 1'b1);
        ret(TW'(4), 1'b1);
        idle(6, 1'b1);

        // Full table: retire and request in one cycle, no same-cycle reuse.
        do_reset(1'b0);
        for (int i = 0; i < NUM; i++) step(1'b1, (i % 2) == 1, 1'b0, 1'b0, TW'(0), 1'b0);
        ret(TW'(0), 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, TW'(0), 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, TW'(0), 1'b0);

        // Stall the consumer, then reset asynchronously mid-stream.
        ret(TW'(1), 1'b0);
        idle(5, 1'b0);
        do_reset(1'b1);

`ifdef RETURN_TIMEOUT_EN
        // Oldest entry force-completes after TO cycles without a return.
        step(1'b1, 1'b0, 1'b0, 1'b0, TW'(0), 1'b0);
        idle(TO, 1'b0);
        chk("t6_timeout_valid", 32'(retire_valid), 32'(1));
        chk("t6_timeout_flag", 32'(retire_timeout), 32'(1));
        step(1'b0, 1'b0, 1'b1, 1'b0, TW'(0), 1'b0);
        idle(2, 1'b1);
        do_reset(1'b0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            t    = TW'($urandom_range(0, NUM - 1));
            kind = $urandom_range(0, 9);
            idx  = m_find(t);
            isr  = (idx >= 0) ? m_q[idx].rd : 1'b0;
            case (kind)
                6: step(($urandom % 3) != 0, 1'($urandom), 1'b1, 1'b0, t, ($urandom % 4) != 0);
                7: step(($urandom % 3) != 0, 1'($urandom), 1'b0, 1'b1, t, ($urandom % 4) != 0);
                8: step(($urandom % 3) != 0, 1'($urandom), 1'b1, 1'b1, t, ($urandom % 4) != 0);
                9: step(($urandom % 3) != 0, 1'($urandom), 1'b0, 1'b0, t, ($urandom % 4) != 0);
                default: step(($urandom % 3) != 0, 1'($urandom), !isr, isr, t, ($urandom % 4) != 0);
            endcase
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
